mem_stage_mc: RTL and testbench
===============================

Name: mem_stage_mc

Overview:
- Parametrised next-generation MIPS MEM stage: internal data memory, MEM/WB pipeline register and branch resolution.
- Adds byte/halfword/word loads and stores with sign or zero extension, and a valid qualifier.
- Memory latency is configurable; the stage stalls upstream while an access is in flight.
- Sits between the EX/MEM register and the write-back stage.

Parameters:
- DATA_W, 32, datapath width; fixed at 32 for byte-lane logic.
- ADDR_W, 10, word-address bits; memory depth is 2**ADDR_W words, indexed by MEM_alu_out[ADDR_W+1:2].
- WAIT_CYCLES, 0, extra cycles per load/store (0..15); 0 gives single-cycle access.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- MEM_valid  in  1  instruction present in MEM
- MEM_ctlwb  in  2  write-back controls, passed through
- MEM_ctlm  in  3  [2] branch, [1] read, [0] write
- MEM_alu_out  in  32  byte address or ALU result
- MEM_alu_zero  in  1  ALU zero flag
- MEM_rd2  in  32  store data
- MEM_rd  in  5  destination register
- MEM_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- MEM_unsigned  in  1  1 = zero-extend loads
- MEM_stall  out  1  hold EX/MEM stable and freeze upstream
- MEM_PCSrc  out  1  branch taken
- WB_valid  out  1  WB registers hold a retired instruction
- WB_ctlwb  out  2  registered controls
- WB_rdata  out  32  registered, extended load data
- WB_alu_out  out  32  registered ALU result
- WB_rd  out  5  registered destination
- WB_misalign  out  1  present only with MEM_ALIGN_TRAP_EN

Behaviour:
- Reset: all WB_* outputs go to 0 and the FSM goes to IDLE. Memory contents are not reset.
- MEM_PCSrc = MEM_valid & ctlm[2] & MEM_alu_zero. It is combinational and never stalled.
- A mem op is MEM_valid & (ctlm[1] | ctlm[0]). If read and write are both set, write wins and rdata is 0.
- FSM IDLE:
  - Non-mem op: WB_* are loaded from the MEM_* inputs at the next edge (1-cycle latency); WB_valid = MEM_valid.
  - Mem op with WAIT_CYCLES=0: completes at the next edge.
  - Mem op with WAIT_CYCLES>0: MEM_stall=1, load cnt=WAIT_CYCLES-1, go to BUSY. WB_valid is loaded with 0 (bubble).
- FSM BUSY:
  - MEM_stall = (cnt!=0); cnt decrements each cycle.
  - On the edge where cnt==0 the access completes, WB_* are loaded and the FSM returns to IDLE.
  - Upstream holds its inputs stable during BUSY. While stall is high, WB_valid is 0 every cycle.
- Total occupancy of a mem op is WAIT_CYCLES+1 cycles. A store commits exactly once, on the completion edge.
- Little-endian lanes:
  - Byte: lane = addr[1:0].
  - Half: lane = addr[1].
  - Stores replicate the low byte/half of rd2 across lanes and write only the enabled lanes.
- Loads: the selected lane is sign-extended, or zero-extended if MEM_unsigned. Words are passed through unchanged.
- WB_rdata is 0 for non-read ops.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
- Address bits above ADDR_W+1 are ignored (the address wraps modulo the memory depth).
- Reset asserted during BUSY: the pending store is not committed, the FSM goes to IDLE, and WB_* are cleared.
- Read-after-write to the same address in back-to-back instructions returns the new data.

Optional Feature:
- MEM_ALIGN_TRAP_EN defined:
  - A misaligned access is suppressed: no memory write, WB_rdata=0, WB_ctlwb forced to 00.
  - WB_misalign=1 for that instruction.
  - Takes full WAIT_CYCLES latency.
- MEM_ALIGN_TRAP_EN undefined:
  - No WB_misalign port.
  - Misaligned addresses are force-aligned: half ignores addr[0], word ignores addr[1:0].

Test Plan:
- WAIT_CYCLES=0: sw 0xDEADBEEF @0x10, then lw @0x10 -> WB_rdata=0xDEADBEEF one cycle after the lw is presented; MEM_stall never asserted.
- lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE; lh @0x12 -> 0xFFFFDEAD; lhu @0x10 -> 0x0000BEEF.
- sb 0x12345677 @0x11 over 0xDEADBEEF -> lw @0x10 returns 0xDEAD77EF.
- WAIT_CYCLES=3: lw -> MEM_stall high for 3 cycles, WB_valid=0 during the stall, WB_valid=1 with correct data at the 4th edge.
- Branch with zero=1, valid=1 -> MEM_PCSrc=1 same cycle. With valid=0 -> MEM_PCSrc=0.
- WAIT_CYCLES=2: sw then rst_n low in BUSY -> memory location unchanged, WB_* all 0.
- Misaligned lh @0x11: with MEM_ALIGN_TRAP_EN -> WB_misalign=1, memory unchanged; without it -> data read from 0x10.

Source files
------------

// File: rtl/mem_stage_mc_if.sv
`default_nettype none
// ============================================================================
// Module : mem_stage_mc_if
// Brief  : EX/MEM -> MEM stage -> WB bundle; WB_misalign exists only when
//          MEM_ALIGN_TRAP_EN is defined.
// Rev    : 1.0
// ============================================================================
interface mem_stage_mc_if;
  logic        MEM_valid;
  logic [1:0]  MEM_ctlwb;
  logic [2:0]  MEM_ctlm;
  logic [31:0] MEM_alu_out;
  logic        MEM_alu_zero;
  logic [31:0] MEM_rd2;
  logic [4:0]  MEM_rd;
  logic [1:0]  MEM_size;
  logic        MEM_unsigned;
  logic        MEM_stall;
  logic        MEM_PCSrc;
  logic        WB_valid;
  logic [1:0]  WB_ctlwb;
  logic [31:0] WB_rdata;
  logic [31:0] WB_alu_out;
  logic [4:0]  WB_rd;
`ifdef MEM_ALIGN_TRAP_EN
  logic        WB_misalign;

  modport master (
    output MEM_valid, MEM_ctlwb, MEM_ctlm, MEM_alu_out, MEM_alu_zero,
           MEM_rd2, MEM_rd, MEM_size, MEM_unsigned,
    input  MEM_stall, MEM_PCSrc, WB_valid, WB_ctlwb, WB_rdata, WB_alu_out,
           WB_rd, WB_misalign
  );
  modport slave (
    input  MEM_valid, MEM_ctlwb, MEM_ctlm, MEM_alu_out, MEM_alu_zero,
           MEM_rd2, MEM_rd, MEM_size, MEM_unsigned,
    output MEM_stall, MEM_PCSrc, WB_valid, WB_ctlwb, WB_rdata, WB_alu_out,
           WB_rd, WB_misalign
  );
`else
  modport master (
    output MEM_valid, MEM_ctlwb, MEM_ctlm, MEM_alu_out, MEM_alu_zero,
           MEM_rd2, MEM_rd, MEM_size, MEM_unsigned,
    input  MEM_stall, MEM_PCSrc, WB_valid, WB_ctlwb, WB_rdata, WB_alu_out,
           WB_rd
  );
  modport slave (
    input  MEM_valid, MEM_ctlwb, MEM_ctlm, MEM_alu_out, MEM_alu_zero,
           MEM_rd2, MEM_rd, MEM_size, MEM_unsigned,
    output MEM_stall, MEM_PCSrc, WB_valid, WB_ctlwb, WB_rdata, WB_alu_out,
           WB_rd
  );
`endif
endinterface
`default_nettype wire

// File: rtl/mem_stage_mc.sv
`default_nettype none
// ============================================================================
// Module : mem_stage_mc
// Brief  : MIPS MEM stage with byte/half/word data memory, configurable access
//          latency, MEM/WB register and branch resolution.
//          Optional macro MEM_ALIGN_TRAP_EN: suppress and flag misaligned access.
// Rev    : 1.0
// ============================================================================
module mem_stage_mc #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input wire            clk,
  input wire            rst_n,
  mem_stage_mc_if.slave bus
);

  localparam logic       HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                wb_valid_q;
  logic [1:0]          wb_ctlwb_q;
  logic [DATA_W-1:0]   wb_rdata_q;
  logic [DATA_W-1:0]   wb_alu_out_q;
  logic [4:0]          wb_rd_q;
  logic                wb_mis_q;
  logic [DATA_W-1:0]   mem_q [2**ADDR_W];

  logic [ADDR_W-1:0]   idx;
  logic [1:0]          lane;
  logic                mem_op, is_wr, is_rd, misalign, done, load_wb, we;
  logic [3:0]          be;
  logic [DATA_W-1:0]   wdata, word_rd, ext, rdata_d;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;

  assign idx    = bus.MEM_alu_out[ADDR_W+1:2];
  assign lane   = bus.MEM_alu_out[1:0];
  assign mem_op = bus.MEM_valid & (bus.MEM_ctlm[1] | bus.MEM_ctlm[0]);
  assign is_wr  = bus.MEM_valid & bus.MEM_ctlm[0];
  assign is_rd  = bus.MEM_valid & bus.MEM_ctlm[1] & ~bus.MEM_ctlm[0];

`ifdef MEM_ALIGN_TRAP_EN
  assign misalign = mem_op & (((bus.MEM_size == 2'b01) & lane[0]) |
                              (bus.MEM_size[1] & (lane != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // With zero wait states an IDLE mem op completes on the very next edge.
  assign done    = (state_q == BUSY) ? (cnt_q == 4'd0) : (mem_op & ~HAS_WAIT);
  assign load_wb = done | ((state_q == IDLE) & ~mem_op);
  assign we      = rst_n & done & is_wr & ~misalign;

  assign bus.MEM_stall = (state_q == BUSY) ? (cnt_q != 4'd0) : (mem_op & HAS_WAIT);
  assign bus.MEM_PCSrc = bus.MEM_valid & bus.MEM_ctlm[2] & bus.MEM_alu_zero;

  always_comb begin
    be    = 4'b1111;
    wdata = bus.MEM_rd2;
    case (bus.MEM_size)
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{bus.MEM_rd2[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.MEM_rd2[15:0]}};
      end
      default: ;
    endcase
  end

  assign word_rd  = mem_q[idx];
  assign byte_sel = word_rd[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? word_rd[31:16] : word_rd[15:0];

  always_comb begin
    ext = word_rd;
    case (bus.MEM_size)
      2'b00:   ext = {{24{~bus.MEM_unsigned & byte_sel[7]}}, byte_sel};
      2'b01:   ext = {{16{~bus.MEM_unsigned & half_sel[15]}}, half_sel};
      default: ;
    endcase
  end

  assign rdata_d = (is_rd & ~misalign) ? ext : '0;

  // Data memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      wb_valid_q   <= 1'b0;
      wb_ctlwb_q   <= 2'b00;
      wb_rdata_q   <= '0;
      wb_alu_out_q <= '0;
      wb_rd_q      <= 5'd0;
      wb_mis_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op && HAS_WAIT) begin
            state_q <= BUSY;
            cnt_q   <= CNT_INIT;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) state_q <= IDLE;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase

      if (load_wb) begin
        wb_valid_q   <= bus.MEM_valid;
        wb_ctlwb_q   <= misalign ? 2'b00 : bus.MEM_ctlwb;
        wb_rdata_q   <= rdata_d;
        wb_alu_out_q <= bus.MEM_alu_out;
        wb_rd_q      <= bus.MEM_rd;
        wb_mis_q     <= misalign;
      end else begin
        wb_valid_q   <= 1'b0;
      end
    end
  end

  assign bus.WB_valid   = wb_valid_q;
  assign bus.WB_ctlwb   = wb_ctlwb_q;
  assign bus.WB_rdata   = wb_rdata_q;
  assign bus.WB_alu_out = wb_alu_out_q;
  assign bus.WB_rd      = wb_rd_q;

`ifdef MEM_ALIGN_TRAP_EN
  assign bus.WB_misalign = wb_mis_q;
`else
  logic unused_mis;
  assign unused_mis = wb_mis_q;
`endif

  // Address bits above the memory index wrap around.
  generate
    if (ADDR_W + 2 < 32) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.MEM_alu_out[31:ADDR_W+2];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_mc.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_stage_mc
// Brief  : Directed bench for mem_stage_mc at WAIT_CYCLES = 0, 3 and 2.
// Rev    : 1.0
// ============================================================================
module tb_mem_stage_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        d_valid [3];
  logic [1:0]  d_ctlwb [3];
  logic [2:0]  d_ctlm  [3];
  logic [31:0] d_addr  [3];
  logic        d_zero  [3];
  logic [31:0] d_rd2   [3];
  logic [4:0]  d_rd    [3];
  logic [1:0]  d_size  [3];
  logic        d_uns   [3];

  logic        o_stall [3];
  logic        o_pcsrc [3];
  logic        o_valid [3];
  logic [1:0]  o_ctlwb [3];
  logic [31:0] o_rdata [3];
  logic [31:0] o_alu   [3];
  logic [4:0]  o_rd    [3];
`ifdef MEM_ALIGN_TRAP_EN
  logic        o_mis   [3];
`endif

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int WT = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
      mem_stage_mc_if u_if ();
      mem_stage_mc #(.DATA_W(32), .ADDR_W(10), .WAIT_CYCLES(WT)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
      );
      assign u_if.MEM_valid    = d_valid[g];
      assign u_if.MEM_ctlwb    = d_ctlwb[g];
      assign u_if.MEM_ctlm     = d_ctlm[g];
      assign u_if.MEM_alu_out  = d_addr[g];
      assign u_if.MEM_alu_zero = d_zero[g];
      assign u_if.MEM_rd2      = d_rd2[g];
      assign u_if.MEM_rd       = d_rd[g];
      assign u_if.MEM_size     = d_size[g];
      assign u_if.MEM_unsigned = d_uns[g];
      assign o_stall[g] = u_if.MEM_stall;
      assign o_pcsrc[g] = u_if.MEM_PCSrc;
      assign o_valid[g] = u_if.WB_valid;
      assign o_ctlwb[g] = u_if.WB_ctlwb;
      assign o_rdata[g] = u_if.WB_rdata;
      assign o_alu[g]   = u_if.WB_alu_out;
      assign o_rd[g]    = u_if.WB_rd;
`ifdef MEM_ALIGN_TRAP_EN
      assign o_mis[g]   = u_if.WB_misalign;
`endif
    end
  endgenerate

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      d_valid[d] = 1'b0; d_ctlwb[d] = 2'b00; d_ctlm[d] = 3'b000;
      d_addr[d]  = '0;   d_zero[d]  = 1'b0;  d_rd2[d]  = '0;
      d_rd[d]    = 5'd0; d_size[d]  = 2'b10; d_uns[d]  = 1'b0;
    end
  endtask

  task automatic op(input int d, input logic [2:0] ctlm, input logic [31:0] addr,
                    input logic [31:0] rd2, input logic [1:0] size, input logic uns);
    d_valid[d] = 1'b1; d_ctlm[d] = ctlm;  d_addr[d] = addr; d_rd2[d] = rd2;
    d_size[d]  = size; d_uns[d]  = uns;   d_ctlwb[d] = 2'b11;
    d_rd[d]    = 5'd7; d_zero[d] = 1'b0;
  endtask

  // Zero-wait DUT: stall must stay low and the result lands one edge later.
  task automatic run0(input string tag, input logic [2:0] ctlm, input logic [31:0] addr,
                      input logic [31:0] rd2, input logic [1:0] size, input logic uns,
                      input logic [31:0] exp_rdata);
    op(0, ctlm, addr, rd2, size, uns);
    #1;
    check({tag, "_stall"}, o_stall[0], 1'b0);
    tick(1);
    check({tag, "_valid"}, o_valid[0], 1'b1);
    check({tag, "_rdata"}, o_rdata[0], exp_rdata);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_all();
    tick(2);
    check("rst_valid0", o_valid[0], 1'b0);
    check("rst_rdata0", o_rdata[0], 32'h0);
    check("rst_alu0",   o_alu[0],   32'h0);
    check("rst_rd0",    o_rd[0],    5'd0);
    check("rst_ctlwb0", o_ctlwb[0], 2'b00);
    check("rst_valid1", o_valid[1], 1'b0);
    check("rst_valid2", o_valid[2], 1'b0);
    rst_n = 1'b1;
    tick(1);

    run0("sw",      3'b001, 32'h10,   32'hDEADBEEF, 2'b10, 1'b0, 32'h0);
    run0("lw",      3'b010, 32'h10,   32'h0,        2'b10, 1'b0, 32'hDEADBEEF);
    run0("lb",      3'b010, 32'h13,   32'h0,        2'b00, 1'b0, 32'hFFFFFFDE);
    run0("lbu",     3'b010, 32'h13,   32'h0,        2'b00, 1'b1, 32'h000000DE);
    run0("lh",      3'b010, 32'h12,   32'h0,        2'b01, 1'b0, 32'hFFFFDEAD);
    run0("lhu",     3'b010, 32'h10,   32'h0,        2'b01, 1'b1, 32'h0000BEEF);
    run0("sb",      3'b001, 32'h11,   32'h12345677, 2'b00, 1'b0, 32'h0);
    run0("lw_sb",   3'b010, 32'h10,   32'h0,        2'b10, 1'b0, 32'hDEAD77EF);
    run0("sh",      3'b001, 32'h12,   32'hAAAA8001, 2'b01, 1'b0, 32'h0);
    run0("lh_sh",   3'b010, 32'h12,   32'h0,        2'b01, 1'b0, 32'hFFFF8001);
    run0("lw_sh",   3'b010, 32'h10,   32'h0,        2'b10, 1'b0, 32'h800177EF);
    run0("sw_wrap", 3'b001, 32'h1010, 32'h0BADF00D, 2'b10, 1'b0, 32'h0);
    run0("lw_wrap", 3'b010, 32'h10,   32'h0,        2'b10, 1'b0, 32'h0BADF00D);
    check("lw_wrap_alu",   o_alu[0],   32'h10);
    check("lw_wrap_rd",    o_rd[0],    5'd7);
    check("lw_wrap_ctlwb", o_ctlwb[0], 2'b11);

`ifdef MEM_ALIGN_TRAP_EN
    run0("lh_mis", 3'b010, 32'h11, 32'h0, 2'b01, 1'b0, 32'h0);
    check("lh_mis_flag",  o_mis[0],   1'b1);
    check("lh_mis_ctlwb", o_ctlwb[0], 2'b00);
    run0("sw_mis", 3'b001, 32'h12, 32'hFFFFFFFF, 2'b10, 1'b0, 32'h0);
    check("sw_mis_flag",  o_mis[0],   1'b1);
    run0("lw_mis", 3'b010, 32'h10, 32'h0, 2'b10, 1'b0, 32'h0BADF00D);
    check("lw_mis_flag",  o_mis[0],   1'b0);
`else
    run0("lh_mis", 3'b010, 32'h11, 32'h0, 2'b01, 1'b0, 32'hFFFFF00D);
    check("lh_mis_ctlwb", o_ctlwb[0], 2'b11);
    run0("sw_mis", 3'b001, 32'h12, 32'hFFFFFFFF, 2'b10, 1'b0, 32'h0);
    run0("lw_mis", 3'b010, 32'h10, 32'h0, 2'b10, 1'b0, 32'hFFFFFFFF);
`endif

    run0("rw_both", 3'b011, 32'h14, 32'h11111111, 2'b10, 1'b0, 32'h0);
    run0("lw_14",   3'b010, 32'h14, 32'h0,        2'b10, 1'b0, 32'h11111111);

    op(0, 3'b000, 32'h12345678, 32'h0, 2'b10, 1'b0);
    d_rd[0] = 5'd9; d_ctlwb[0] = 2'b10;
    tick(1);
    check("alu_op_alu",   o_alu[0],   32'h12345678);
    check("alu_op_rd",    o_rd[0],    5'd9);
    check("alu_op_ctlwb", o_ctlwb[0], 2'b10);
    check("alu_op_rdata", o_rdata[0], 32'h0);
    check("alu_op_valid", o_valid[0], 1'b1);

    op(0, 3'b100, 32'h0, 32'h0, 2'b10, 1'b0);
    d_zero[0] = 1'b1;
    #1 check("br_taken", o_pcsrc[0], 1'b1);
    d_valid[0] = 1'b0;
    #1 check("br_novalid", o_pcsrc[0], 1'b0);
    d_valid[0] = 1'b1; d_zero[0] = 1'b0;
    #1 check("br_nozero", o_pcsrc[0], 1'b0);
    idle_all();
    tick(1);
    check("bubble_valid", o_valid[0], 1'b0);

    // WAIT_CYCLES = 3
    op(1, 3'b001, 32'h20, 32'hDEADBEEF, 2'b10, 1'b0);
    tick(4);
    check("w3_sw_valid", o_valid[1], 1'b1);
    op(1, 3'b010, 32'h20, 32'h0, 2'b10, 1'b0);
    #1 check("w3_stall_c0", o_stall[1], 1'b1);
    tick(1);
    check("w3_stall_c1", o_stall[1], 1'b1);
    check("w3_valid_c1", o_valid[1], 1'b0);
    tick(1);
    check("w3_stall_c2", o_stall[1], 1'b1);
    check("w3_valid_c2", o_valid[1], 1'b0);
    tick(1);
    check("w3_stall_c3", o_stall[1], 1'b0);
    check("w3_valid_c3", o_valid[1], 1'b0);
    tick(1);
    check("w3_valid_c4", o_valid[1], 1'b1);
    check("w3_rdata",    o_rdata[1], 32'hDEADBEEF);
    idle_all();
    #1 check("w3_stall_idle", o_stall[1], 1'b0);
    tick(1);
    check("w3_valid_idle", o_valid[1], 1'b0);

    // WAIT_CYCLES = 2 with reset during BUSY
    op(2, 3'b001, 32'h30, 32'h55AA55AA, 2'b10, 1'b0);
    tick(3);
    op(2, 3'b010, 32'h30, 32'h0, 2'b10, 1'b0);
    tick(3);
    check("w2_lw_rdata", o_rdata[2], 32'h55AA55AA);
    op(2, 3'b001, 32'h30, 32'h12345678, 2'b10, 1'b0);
    tick(1);
    check("w2_busy_stall", o_stall[2], 1'b1);
    rst_n = 1'b0;
    #1;
    check("w2_rst_valid", o_valid[2], 1'b0);
    check("w2_rst_rdata", o_rdata[2], 32'h0);
    check("w2_rst_alu",   o_alu[2],   32'h0);
    check("w2_rst_rd",    o_rd[2],    5'd0);
    check("w2_rst_ctlwb", o_ctlwb[2], 2'b00);
    tick(2);
    idle_all();
    rst_n = 1'b1;
    tick(1);
    op(2, 3'b010, 32'h30, 32'h0, 2'b10, 1'b0);
    tick(3);
    check("w2_after_rst_valid", o_valid[2], 1'b1);
    check("w2_after_rst_rdata", o_rdata[2], 32'h55AA55AA);
    idle_all();
    tick(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
